jtframe_dwnld_pack: RTL

//  Successor ROM downloader between the ioctl byte stream and jtframe_sdram. Packs byte pairs into
//  16-bit words, maps them to up to 4 SDRAM banks and buffers them in a FIFO, so ioctl_wr never

---
 rtl/jtframe_dwnld_pkg.sv | 15 +
 rtl/jtframe_dwnld_fifo.sv | 32 +++
 rtl/jtframe_dwnld_pack.sv | 122 ++++++++++++
 3 files changed

// File: rtl/jtframe_dwnld_pkg.sv
// jtframe_dwnld_pkg: shared constants, FSM encodings and byte-lane helper for the ROM downloader
package jtframe_dwnld_pkg;
  localparam logic [25:0] NO_START = ~26'd0;
  localparam logic [1:0] MASK_WORD = 2'b00;
  localparam logic [1:0] MASK_LO = 2'b10;
  localparam logic [1:0] MASK_HI = 2'b01;
  localparam logic [0:0] PK_IDLE = 1'b0;
  localparam logic [0:0] PK_HALF = 1'b1;
  localparam logic [1:0] OUT_EMPTY = 2'd0;
  localparam logic [1:0] OUT_PRESENT = 2'd1;
  localparam logic [1:0] OUT_GAP = 2'd2;
  function automatic logic [15:0] lane(input logic [7:0] b, input logic hi);
    return hi ? {b, 8'h00} : {8'h00, b};
  endfunction
endpackage

// File: rtl/jtframe_dwnld_fifo.sv
// jtframe_dwnld_fifo: synchronous FIFO of 2**AW entries; a push on full is taken only with a pop
module jtframe_dwnld_fifo #(
  parameter int W = 8,
  parameter int AW = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  logic [W-1:0] mem [2**AW];
  logic [AW:0] wr, rd;
  logic wen;
  assign empty = wr == rd;
  assign full = wr == {~rd[AW], rd[AW-1:0]};
  assign wen = push && (!full || pop);
  assign dout = mem[rd[AW-1:0]];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr <= '0;
      rd <= '0;
    end else begin
      if (wen) wr <= wr + 1'b1;
      if (pop && !empty) rd <= rd + 1'b1;
    end
  always_ff @(posedge clk)
    if (wen) mem[wr[AW-1:0]] <= din;
endmodule

// File: rtl/jtframe_dwnld_pack.sv
// jtframe_dwnld_pack: packs ioctl bytes into banked 16-bit SDRAM writes through a FIFO, PROM bytes bypass it.
// Define JTFRAME_DWNLD_CHKSUM_EN to build the byte checksum; otherwise chksum is tied to zero.
module jtframe_dwnld_pack import jtframe_dwnld_pkg::*; #(
  parameter int          AW         = 22,
  parameter logic [25:0] BA1_START  = NO_START,
  parameter logic [25:0] BA2_START  = NO_START,
  parameter logic [25:0] BA3_START  = NO_START,
  parameter logic [25:0] PROM_START = NO_START,
  parameter logic [25:0] HEADER     = 26'd0,
  parameter bit          SWAB       = 1'b0,
  parameter int          FIFO_AW    = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          downloading,
  input  logic [25:0]   ioctl_addr,
  input  logic [7:0]    ioctl_dout,
  input  logic          ioctl_wr,
  output logic          header,
  output logic [AW-1:0] prog_addr,
  output logic [15:0]   prog_data,
  output logic [1:0]    prog_mask,
  output logic [1:0]    prog_ba,
  output logic          prog_we,
  input  logic          sdram_ack,
  output logic          prom_we,
  output logic [21:0]   prom_addr,
  output logic [7:0]    prom_data,
  output logic          busy,
  output logic          overflow,
  output logic [15:0]   chksum
);
  localparam int EW = AW + 20;
  logic [25:0] part, start, eff;
  logic [1:0] ba, ost, h_ba;
  logic [0:0] pk;
  logic [24:0] h_word;
  logic [7:0] h_byte;
  logic acc, is_prom, sd, pair, flush, lone, in_v, sk_v, pop, full, empty, drop, dl_l, rise;
  logic [EW-1:0] n0, n1, in_e, sk_e, head;
  assign header = downloading && ioctl_addr < HEADER;
  assign part = ioctl_addr - HEADER;
  assign ba = BA3_START != NO_START && part >= BA3_START ? 2'd3 :
              BA2_START != NO_START && part >= BA2_START ? 2'd2 :
              BA1_START != NO_START && part >= BA1_START ? 2'd1 : 2'd0;
  assign start = ba == 2'd3 ? BA3_START : ba == 2'd2 ? BA2_START : ba == 2'd1 ? BA1_START : 26'd0;
  assign eff = part - start;
  assign acc = ioctl_wr && downloading && !header;
  assign is_prom = PROM_START != NO_START && part >= PROM_START;
  assign sd = acc && !is_prom;
  assign pair = pk == PK_HALF && sd && eff[0] && h_ba == ba && h_word == eff[25:1];
  assign flush = pk == PK_HALF && !pair && (acc || !downloading);
  assign lone = sd && eff[0] && !pair;
  assign n0 = {h_ba, h_word[AW-1:0], lane(h_byte, SWAB), SWAB ? MASK_HI : MASK_LO};
  assign n1 = {ba, eff[AW:1], (pair ? lane(h_byte, SWAB) : 16'd0) | lane(ioctl_dout, !SWAB),
               pair ? MASK_WORD : SWAB ? MASK_LO : MASK_HI};
  assign pop = ost == OUT_PRESENT && sdram_ack;
  assign drop = (in_v && full && !pop) || (sk_v && flush && (pair || lone));
  assign rise = downloading && !dl_l;
  assign prog_we = ost == OUT_PRESENT;
  assign busy = pk == PK_HALF || in_v || sk_v || !empty || prog_we;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pk <= PK_IDLE;
      h_ba <= '0;
      h_word <= '0;
      h_byte <= '0;
      in_v <= 1'b0;
      in_e <= '0;
      sk_v <= 1'b0;
      sk_e <= '0;
    end else begin
      pk <= sd && !eff[0] ? PK_HALF : flush || pair ? PK_IDLE : pk;
      if (sd && !eff[0]) begin
        h_ba <= ba;
        h_word <= eff[25:1];
        h_byte <= ioctl_dout;
      end
      // a flush and a new entry in one cycle: the second waits in the skid
      in_v <= sk_v || flush || pair || lone;
      in_e <= sk_v ? sk_e : flush ? n0 : n1;
      sk_v <= sk_v ? flush || pair || lone : flush && (pair || lone);
      sk_e <= sk_v && flush ? n0 : n1;
    end
  jtframe_dwnld_fifo #(.W(EW), .AW(FIFO_AW)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (in_v),
    .pop   (pop),
    .din   (in_e),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ost <= OUT_EMPTY;
      {prog_ba, prog_addr, prog_data, prog_mask} <= '0;
      dl_l <= 1'b0;
      overflow <= 1'b0;
      prom_we <= 1'b0;
      prom_addr <= '0;
      prom_data <= '0;
    end else begin
      ost <= ost == OUT_PRESENT ? (sdram_ack ? OUT_GAP : OUT_PRESENT) : (empty ? OUT_EMPTY : OUT_PRESENT);
      if (ost != OUT_PRESENT && !empty) {prog_ba, prog_addr, prog_data, prog_mask} <= head;
      dl_l <= downloading;
      overflow <= (rise ? 1'b0 : overflow) | drop;
      prom_we <= acc && is_prom;
      if (acc && is_prom) begin
        prom_addr <= 22'(part - PROM_START);
        prom_data <= ioctl_dout;
      end
    end
`ifdef JTFRAME_DWNLD_CHKSUM_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) chksum <= '0;
    else chksum <= (rise ? 16'd0 : chksum) + (acc ? {8'd0, ioctl_dout} : 16'd0);
`else
  assign chksum = 16'd0;
`endif
endmodule
